// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: hazard inputs from ID/EX/MEM and the
// pipeline-register controls, debug state and performance counters it returns.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic             ex_memRead;
  logic [4:0]       ex_rd;
  logic             mem_redirect;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_bubble;
  logic             pipe_hold;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: drives hazard terms, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_memRead, ex_rd,
           mem_redirect, mem_access, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_mem_bubble, pipe_hold, state, stall_cnt, flush_cnt
  );

  // Hazard controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_memRead, ex_rd,
           mem_redirect, mem_access, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_mem_bubble, pipe_hold, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage RV32 pipe (load-use, MEM redirect, dmem wait).
// Lost-cycle counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_ctrl #(
  parameter int LU_STALLS = 1,
  parameter int CNT_W     = 32
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [1:0] LU_INIT = 2'(LU_STALLS - 1);

  state_e     state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       lu_s, mw_s;
  logic       pc_write_s, if_id_write_s, if_id_flush_s;
  logic       id_ex_bubble_s, ex_mem_bubble_s, pipe_hold_s;

  // Hazard detection, priority resolution and next-state selection.
  always_comb begin
    lu_s = hz.ex_memRead && (hz.ex_rd != 5'd0) &&
           ((hz.ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));
    mw_s = hz.mem_access && !hz.dmem_ready;

    pc_write_s      = 1'b1;
    if_id_write_s   = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_bubble_s  = 1'b0;
    ex_mem_bubble_s = 1'b0;
    pipe_hold_s     = 1'b0;
    state_d         = RUN;
    lu_cnt_d        = 2'd0;

    if (reset) begin
      pc_write_s      = 1'b0;
      if_id_write_s   = 1'b0;
      if_id_flush_s   = 1'b1;
      id_ex_bubble_s  = 1'b1;
      ex_mem_bubble_s = 1'b1;
    end else if (mw_s) begin
      // Freeze everything; any pending stall count or flush duty is dropped.
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      pipe_hold_s   = 1'b1;
      state_d       = MEM_WAIT;
    end else if (hz.mem_redirect) begin
      if_id_flush_s   = 1'b1;
      id_ex_bubble_s  = 1'b1;
      ex_mem_bubble_s = 1'b1;
      state_d         = FLUSH;
    end else if (state_q == LU_STALL) begin
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      id_ex_bubble_s = 1'b1;
      if (lu_cnt_q > 2'd1) begin
        state_d  = LU_STALL;
        lu_cnt_d = lu_cnt_q - 2'd1;
      end else begin
        state_d  = RUN;
        lu_cnt_d = 2'd0;
      end
    end else begin
      // RUN, FLUSH and the releasing MEM_WAIT cycle all evaluate like RUN.
      if (state_q == FLUSH) begin
        if_id_flush_s = 1'b1;
      end else begin
        if_id_flush_s = 1'b0;
      end
      if (lu_s) begin
        pc_write_s     = 1'b0;
        if_id_write_s  = 1'b0;
        id_ex_bubble_s = 1'b1;
        if (LU_STALLS > 1) begin
          state_d  = LU_STALL;
          lu_cnt_d = LU_INIT;
        end else begin
          state_d  = RUN;
          lu_cnt_d = 2'd0;
        end
      end else begin
        state_d  = RUN;
        lu_cnt_d = 2'd0;
      end
    end
  end

  // FSM state and load-use stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      lu_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign hz.pc_write      = pc_write_s;
  assign hz.if_id_write   = if_id_write_s;
  assign hz.if_id_flush   = if_id_flush_s;
  assign hz.id_ex_bubble  = id_ex_bubble_s;
  assign hz.ex_mem_bubble = ex_mem_bubble_s;
  assign hz.pipe_hold     = pipe_hold_s;
  assign hz.state         = reset ? RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             redirect_ev_s;

  // Saturating lost-cycle and redirect-event counters.
  always_comb begin
    redirect_ev_s = hz.mem_redirect && !mw_s;
    if (!pc_write_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_ev_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: dut_a (LU_STALLS=1, CNT_W=32) and dut_b (LU_STALLS=3, CNT_W=4)
// share stimulus; per-cycle control expectations are queued and checked on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memRead, mem_redirect, mem_access, dmem_ready;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hif_a ();
  hazard_ctrl_if #(.CNT_W(4))  hif_b ();

  assign hif_a.id_rs1 = id_rs1;             assign hif_b.id_rs1 = id_rs1;
  assign hif_a.id_rs2 = id_rs2;             assign hif_b.id_rs2 = id_rs2;
  assign hif_a.id_uses_rs2 = id_uses_rs2;   assign hif_b.id_uses_rs2 = id_uses_rs2;
  assign hif_a.ex_memRead = ex_memRead;     assign hif_b.ex_memRead = ex_memRead;
  assign hif_a.ex_rd = ex_rd;               assign hif_b.ex_rd = ex_rd;
  assign hif_a.mem_redirect = mem_redirect; assign hif_b.mem_redirect = mem_redirect;
  assign hif_a.mem_access = mem_access;     assign hif_b.mem_access = mem_access;
  assign hif_a.dmem_ready = dmem_ready;     assign hif_b.dmem_ready = dmem_ready;

  hazard_ctrl #(.LU_STALLS(1), .CNT_W(32)) u_dut_a (.clk(clk), .reset(reset), .hz(hif_a));
  hazard_ctrl #(.LU_STALLS(3), .CNT_W(4))  u_dut_b (.clk(clk), .reset(reset), .hz(hif_b));

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble, pipe_hold}
  localparam logic [5:0] O_RUN = 6'b110000;
  localparam logic [5:0] O_LU  = 6'b000100;
  localparam logic [5:0] O_MW  = 6'b000001;
  localparam logic [5:0] O_RD  = 6'b111110;
  localparam logic [5:0] O_FL  = 6'b111000;
  localparam logic [5:0] O_RST = 6'b001110;

  typedef struct {
    string      tag;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  n_total = 0;
  int  n_bad   = 0;

  wire [7:0] obs_a = {hif_a.pc_write, hif_a.if_id_write, hif_a.if_id_flush,
                      hif_a.id_ex_bubble, hif_a.ex_mem_bubble, hif_a.pipe_hold, hif_a.state};
  wire [7:0] obs_b = {hif_b.pc_write, hif_b.if_id_write, hif_b.if_id_flush,
                      hif_b.id_ex_bubble, hif_b.ex_mem_bubble, hif_b.pipe_hold, hif_b.state};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int unsigned v, input int unsigned maxv);
    if (!PERF) return 32'd0;
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic cyc(input string tag, input logic [5:0] ca, input logic [1:0] sa,
                     input logic [5:0] cb, input logic [1:0] sb_st);
    sb_t e;
    e.tag   = tag;
    e.exp_a = {ca, sa};
    e.exp_b = {cb, sb_st};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int unsigned sa, input int unsigned sbv,
                           input int unsigned fa, input int unsigned fb);
    check_eq({tag, "_stall_a"}, hif_a.stall_cnt, ecnt(sa, 32'hFFFF_FFFF));
    check_eq({tag, "_stall_b"}, 32'(hif_b.stall_cnt), ecnt(sbv, 15));
    check_eq({tag, "_flush_a"}, hif_a.flush_cnt, ecnt(fa, 32'hFFFF_FFFF));
    check_eq({tag, "_flush_b"}, 32'(hif_b.flush_cnt), ecnt(fb, 15));
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; id_uses_rs2 = 1'b0;
    ex_memRead = 1'b0; mem_redirect = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu();
    ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
  endtask

  // Combinational controls are compared mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check_eq({mon_e.tag, "/a"}, 32'(obs_a), 32'(mon_e.exp_a));
      check_eq({mon_e.tag, "/b"}, 32'(obs_b), 32'(mon_e.exp_b));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst0", O_RST, 2'd0, O_RST, 2'd0);
    cyc("rst1", O_RST, 2'd0, O_RST, 2'd0);
    reset = 1'b0;
    cyc("run0", O_RUN, 2'd0, O_RUN, 2'd0);

    // Reset asserted in the middle of a memory wait.
    mem_access = 1'b1;
    cyc("t1_mw0", O_MW, 2'd0, O_MW, 2'd0);
    cyc("t1_mw1", O_MW, 2'd2, O_MW, 2'd2);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t1_rst", O_RST, 2'd0, O_RST, 2'd0);
    reset = 1'b0; mem_access = 1'b0;
    cyc("t1_run", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t1", 0, 0, 0, 0);

    // Load-use on rs1: 1 stall for dut_a, 3 for dut_b.
    set_lu();
    cyc("t2_lu", O_LU, 2'd0, O_LU, 2'd0);
    idle();
    cyc("t2_s1", O_RUN, 2'd0, O_LU, 2'd1);
    cyc("t2_s2", O_RUN, 2'd0, O_LU, 2'd1);
    cyc("t2_end", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t2", 1, 3, 0, 0);

    // ex_rd==0 and unused rs2 produce no hazard; a used rs2 does.
    ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    cyc("t3_rd0", O_RUN, 2'd0, O_RUN, 2'd0);
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    cyc("t3_nors2", O_RUN, 2'd0, O_RUN, 2'd0);
    id_uses_rs2 = 1'b1;
    cyc("t3_rs2", O_LU, 2'd0, O_LU, 2'd0);
    idle();
    cyc("t3_s1", O_RUN, 2'd0, O_LU, 2'd1);
    cyc("t3_s2", O_RUN, 2'd0, O_LU, 2'd1);
    cyc("t3_end", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t3", 2, 6, 0, 0);

    // Redirect then one FLUSH cycle.
    mem_redirect = 1'b1;
    cyc("t4_rd", O_RD, 2'd0, O_RD, 2'd0);
    idle();
    cyc("t4_fl", O_FL, 2'd3, O_FL, 2'd3);
    cyc("t4_run", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t4", 2, 6, 1, 1);

    // Four wait-state cycles, release on ready.
    mem_access = 1'b1; dmem_ready = 1'b0;
    cyc("t5_mw0", O_MW, 2'd0, O_MW, 2'd0);
    for (int i = 0; i < 3; i++) cyc("t5_mw", O_MW, 2'd2, O_MW, 2'd2);
    dmem_ready = 1'b1;
    cyc("t5_rdy", O_RUN, 2'd2, O_RUN, 2'd2);
    idle();
    cyc("t5_run", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t5", 6, 10, 1, 1);

    // Load-use and redirect together: redirect wins, no stall.
    set_lu(); mem_redirect = 1'b1;
    cyc("t6_rd", O_RD, 2'd0, O_RD, 2'd0);
    idle();
    cyc("t6_fl", O_FL, 2'd3, O_FL, 2'd3);
    cyc("t6_run", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t6", 6, 10, 2, 2);

    // Redirect aborts an ongoing multi-cycle stall.
    set_lu();
    cyc("t7_lu", O_LU, 2'd0, O_LU, 2'd0);
    idle(); mem_redirect = 1'b1;
    cyc("t7_abort", O_RD, 2'd0, O_RD, 2'd1);
    idle();
    cyc("t7_fl", O_FL, 2'd3, O_FL, 2'd3);
    cyc("t7_run", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t7", 7, 11, 3, 3);

    // Memory wait during FLUSH drops the flush cycle.
    mem_redirect = 1'b1;
    cyc("t8_rd", O_RD, 2'd0, O_RD, 2'd0);
    idle(); mem_access = 1'b1;
    cyc("t8_mwfl", O_MW, 2'd3, O_MW, 2'd3);
    cyc("t8_mw", O_MW, 2'd2, O_MW, 2'd2);
    idle();
    cyc("t8_exit", O_RUN, 2'd2, O_RUN, 2'd2);
    cyc("t8_run", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t8", 9, 13, 4, 4);

    // 20 wait cycles saturate the 4-bit counter; wait beats a coincident redirect.
    mem_access = 1'b1; mem_redirect = 1'b1;
    cyc("t9_mwrd", O_MW, 2'd0, O_MW, 2'd0);
    mem_redirect = 1'b0;
    for (int i = 0; i < 19; i++) cyc("t9_mw", O_MW, 2'd2, O_MW, 2'd2);
    idle();
    cyc("t9_exit", O_RUN, 2'd2, O_RUN, 2'd2);
    cyc("t9_run", O_RUN, 2'd0, O_RUN, 2'd0);
    check_cnt("t9", 29, 33, 4, 4);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
